// File: rtl/nbiot_sc_demapper.sv
// NB-IoT uplink receive subcarrier demapper: captures a 12-tone symbol and serialises the ISC-allocated tones.
// Optional macro NBIOT_SC_DEMAP_CNT_EN adds the sym_cnt completed-symbol counter port.
module nbiot_sc_demapper #(
  parameter int unsigned DW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       isc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12*DW-1:0] in_rl_flat,
  input  logic [12*DW-1:0] in_img_flat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_rl,
  output logic [DW-1:0]    out_img,
  output logic [3:0]       out_sc_idx,
  output logic             out_last,
`ifdef NBIOT_SC_DEMAP_CNT_EN
  output logic [15:0]      sym_cnt,
`endif
  output logic             err_isc
);

  typedef enum logic {IDLE, SERIAL} state_e;

  state_e          state_q;
  logic            out_valid_q, out_last_q, err_q;
  logic [DW-1:0]   out_rl_q, out_img_q;
  logic [3:0]      out_sc_idx_q, start_q, num_q, cnt_q;
  logic [DW-1:0]   rl_q  [12];
  logic [DW-1:0]   img_q [12];

  logic [DW-1:0]   lane_rl  [12];
  logic [DW-1:0]   lane_img [12];
  logic            isc_ok;
  logic [3:0]      dec_s, dec_n, next_idx;
  logic            accept, beat_hs, load;

  always_comb begin
    for (int unsigned k = 0; k < 12; k++) begin
      lane_rl[k]  = in_rl_flat[k*DW +: DW];
      lane_img[k] = in_img_flat[k*DW +: DW];
    end
  end

  always_comb begin
    isc_ok = 1'b1;
    dec_s  = '0;
    dec_n  = 4'd1;
    if (isc < 5'd12) begin
      dec_s = isc[3:0];
    end else if (isc < 5'd16) begin
      dec_s = 4'(isc[1:0]) * 4'd3;
      dec_n = 4'd3;
    end else if (isc < 5'd18) begin
      dec_s = isc[0] ? 4'd6 : 4'd0;
      dec_n = 4'd6;
    end else if (isc == 5'd18) begin
      dec_n = 4'd12;
    end else begin
      isc_ok = 1'b0;
    end
  end

  // A new symbol may enter only while idle or on the handshake of the final beat.
  assign beat_hs  = out_valid_q & out_ready;
  assign in_ready = (state_q == IDLE) | ((state_q == SERIAL) & beat_hs & out_last_q);
  assign accept   = in_valid & in_ready;
  assign load     = accept & isc_ok;
  assign next_idx = start_q + cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_rl_q     <= '0;
      out_img_q    <= '0;
      out_sc_idx_q <= '0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      start_q      <= '0;
      num_q        <= 4'd1;
    end else begin
      err_q <= accept & ~isc_ok;
      if (load) begin
        rl_q         <= lane_rl;
        img_q        <= lane_img;
        start_q      <= dec_s;
        num_q        <= dec_n;
        cnt_q        <= '0;
        state_q      <= SERIAL;
        out_valid_q  <= 1'b1;
        out_rl_q     <= lane_rl[dec_s];
        out_img_q    <= lane_img[dec_s];
        out_sc_idx_q <= dec_s;
        out_last_q   <= (dec_n == 4'd1);
      end else if ((state_q == SERIAL) && beat_hs) begin
        if (out_last_q) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end else begin
          cnt_q        <= cnt_q + 4'd1;
          out_rl_q     <= rl_q[next_idx];
          out_img_q    <= img_q[next_idx];
          out_sc_idx_q <= next_idx;
          out_last_q   <= ((cnt_q + 4'd2) == num_q);
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rl     = out_rl_q;
  assign out_img    = out_img_q;
  assign out_sc_idx = out_sc_idx_q;
  assign out_last   = out_last_q;
  assign err_isc    = err_q;

`ifdef NBIOT_SC_DEMAP_CNT_EN
  logic [15:0] sym_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_cnt_q <= '0;
    end else if (beat_hs && out_last_q) begin
      sym_cnt_q <= sym_cnt_q + 16'd1;
    end
  end

  assign sym_cnt = sym_cnt_q;
`endif

endmodule
